gups_sys: RTL and testbench

//  Random-access update engine (GUPS-style) for memory-bandwidth tests. Generates pseudo-random word

---
 rtl/gups_pkg.sv | 26 ++
 rtl/lfsr16.sv | 22 ++
 rtl/gups_sys.sv | 92 +++++++++
 tb/tb_gups_sys.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gups_pkg.sv
// Shared definitions for the GUPS random-access update engine: widths,
// LFSR constants, the update FSM state type and the LFSR step function.
package gups_pkg;

  localparam int DATA_W = 64;
  localparam int SEED_W = 16;
  localparam int LANES  = DATA_W / SEED_W;

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  // An all-zero seed would lock the LFSR, so it is replaced by this value
  localparam logic [15:0] ZERO_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    GAP
  } state_t;

  // One Fibonacci step: shift left, XOR of the tapped bits enters at bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// One 16-bit Fibonacci LFSR lane. Loads its seed while reset is held and
// advances one step whenever step is high.
module lfsr16
  import gups_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  // Seed load on reset (zero swapped for a legal state), otherwise step on demand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= (seed == 16'h0000) ? ZERO_SEED : seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/gups_sys.sv
// GUPS-style update engine: draws a masked pseudo-random word address from
// four LFSR lanes and performs an atomic read-increment-write on it over a
// req/wr/rdy memory port. All port outputs are registered and held steady
// while the memory takes its time to answer.
module gups_sys
  import gups_pkg::*;
#(
  parameter int DATA_W = gups_pkg::DATA_W,
  parameter int SEED_W = gups_pkg::SEED_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              req,
  output logic              wr,
  input  logic              rdy,
  input  logic [SEED_W-1:0] seed0,
  input  logic [SEED_W-1:0] seed1,
  input  logic [SEED_W-1:0] seed2,
  input  logic [SEED_W-1:0] seed3,
  input  logic [DATA_W-1:0] range
);

  state_t            state;
  logic              step;
  logic [SEED_W-1:0] lane_seed [LANES];
  logic [SEED_W-1:0] lane_q    [LANES];
  logic [DATA_W-1:0] rnd;

  assign lane_seed[0] = seed0;
  assign lane_seed[1] = seed1;
  assign lane_seed[2] = seed2;
  assign lane_seed[3] = seed3;

  // Lanes advance exactly once per update, as the new address is taken
  assign step = (state == IDLE);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    lfsr16 u_lane (
      .clk  (clk),
      .rst  (rst),
      .seed (lane_seed[gi]),
      .step (step),
      .q    (lane_q[gi])
    );
  end

  assign rnd = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};

  // Update FSM: issue read, turn returned data into write of data+1, then idle one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req   <= 1'b0;
      wr    <= 1'b0;
      addr  <= '0;
      dout  <= '0;
    end else begin
      case (state)
        IDLE: begin
          addr  <= rnd & range;
          req   <= 1'b1;
          wr    <= 1'b0;
          state <= RD;
        end
        RD: begin
          if (rdy) begin
            dout  <= din + DATA_W'(1);
            wr    <= 1'b1;
            state <= WR;
          end
        end
        WR: begin
          if (rdy) begin
            req   <= 1'b0;
            wr    <= 1'b0;
            state <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gups_sys.sv
// Self-checking bench for gups_sys: behavioural memory with programmable
// latency, an LFSR reference model for the address stream and a scoreboard
// of expected write-backs.
module tb_gups_sys;

  logic        clk;
  logic        rst;
  logic [63:0] addr;
  logic [63:0] din;
  logic [63:0] dout;
  logic        req;
  logic        wr;
  logic        rdy;
  logic [15:0] seed0, seed1, seed2, seed3;
  logic [63:0] range_val;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } exp_t;

  typedef struct {
    logic [15:0] s0, s1, s2, s3;
    logic [63:0] rng;
    logic [63:0] fill;
    int          rl, wl;
    logic [63:0] exp_addr;
    logic [63:0] exp_dout;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [63:0] mem [256];
  logic [15:0] m_lane [4];
  int          rd_lat, wr_lat;
  bit          rand_lat, stray_en;
  int          write_count = 0;
  int          rd_changes = 0;
  bit          first_rd = 1;
  logic [63:0] last_rd_addr = '0;
  logic [63:0] last_wr_addr = '0;
  logic [63:0] last_wr_dout = '0;
  vec_t        vecs [5];

  gups_sys dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .req   (req),
    .wr    (wr),
    .rdy   (rdy),
    .seed0 (seed0),
    .seed1 (seed1),
    .seed2 (seed2),
    .seed3 (seed3),
    .range (range_val)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] ref_seed(input logic [15:0] s);
    return (s == 16'h0) ? 16'hACE1 : s;
  endfunction

  task automatic model_reset();
    m_lane[0] = ref_seed(seed0);
    m_lane[1] = ref_seed(seed1);
    m_lane[2] = ref_seed(seed2);
    m_lane[3] = ref_seed(seed3);
  endtask

  // Memory model and protocol monitor, acting 1 unit after each rising edge
  initial begin : mem_model
    int          cnt;
    int          lat;
    bit          busy;
    bit          is_wr;
    logic [63:0] h_addr;
    logic [63:0] h_dout;
    logic [63:0] exp_a;
    logic [7:0]  idx;
    exp_t        e;
    rdy = 1'b0; din = '0; busy = 0; cnt = 0; is_wr = 0; h_addr = '0; h_dout = '0;
    forever begin
      @(posedge clk); #1;
      rdy = 1'b0;
      if (rst) begin
        busy = 0;
        sb.delete();
        model_reset();
        first_rd = 1;
        rd_changes = 0;
        continue;
      end
      if (busy) begin
        check_output("hold_req",  {63'b0, req}, 64'd1);
        check_output("hold_wr",   {63'b0, wr}, {63'b0, is_wr});
        check_output("hold_addr", addr, h_addr);
        check_output("hold_dout", dout, h_dout);
        cnt--;
      end else if (req) begin
        is_wr  = wr;
        h_addr = addr;
        h_dout = dout;
        if (!wr) begin
          exp_a = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]} & range_val;
          check_output("rd_addr", addr, exp_a);
          check_output("addr_in_range", addr & ~range_val, 64'd0);
          for (int i = 0; i < 4; i++) m_lane[i] = ref_step(m_lane[i]);
          if (!first_rd && addr != last_rd_addr) rd_changes++;
          last_rd_addr = addr;
          first_rd = 0;
        end
        lat = is_wr ? wr_lat : rd_lat;
        if (rand_lat) lat = int'($urandom_range(1, 6));
        cnt  = lat - 1;
        busy = 1;
      end else if (stray_en) begin
        rdy = 1'b1;
      end
      if (busy && cnt == 0) begin
        busy = 0;
        rdy  = 1'b1;
        idx  = h_addr[7:0];
        if (!is_wr) begin
          din = mem[idx];
          sb.push_back('{a: h_addr, d: mem[idx] + 64'd1});
        end else begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_pop: write at %h with no pending read", h_addr);
          end else begin
            e = sb.pop_front();
            check_output("wr_addr", h_addr, e.a);
            check_output("wr_data", h_dout, e.d);
          end
          mem[idx]     = h_dout;
          last_wr_addr = h_addr;
          last_wr_dout = h_dout;
          write_count++;
        end
      end
    end
  end

  task automatic wait_writes(input int n, input int bound, input string name);
    int target;
    int cyc;
    target = write_count + n;
    cyc = 0;
    while (write_count < target && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check_output(name, {63'b0, write_count >= target}, 64'd1);
  endtask

  task automatic apply_stimulus(input vec_t v, input int k);
    bit found;
    @(negedge clk);
    rst = 1'b1;
    seed0 = v.s0; seed1 = v.s1; seed2 = v.s2; seed3 = v.s3;
    range_val = v.rng;
    for (int i = 0; i < 256; i++) mem[i] = v.fill;
    rd_lat = v.rl; wr_lat = v.wl; rand_lat = 0; stray_en = 0;
    repeat (3) @(negedge clk);
    check_output($sformatf("rst_req_%0d", k),  {63'b0, req}, 64'd0);
    check_output($sformatf("rst_wr_%0d", k),   {63'b0, wr}, 64'd0);
    check_output($sformatf("rst_addr_%0d", k), addr, 64'd0);
    check_output($sformatf("rst_dout_%0d", k), dout, 64'd0);
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 2 && !found; i++) begin
      @(posedge clk); #2;
      if (req) found = 1;
    end
    check_output($sformatf("first_req_%0d", k), {63'b0, found}, 64'd1);
    wait_writes(1, 80, $sformatf("first_write_%0d", k));
    check_output($sformatf("vec_addr_%0d", k), last_wr_addr, v.exp_addr);
    check_output($sformatf("vec_dout_%0d", k), last_wr_dout, v.exp_dout);
  endtask

  // Main sequence: table vectors, corner-case sequences, then a long random run
  initial begin : stim
    int polls;
    rst = 1'b1;
    seed0 = '0; seed1 = '0; seed2 = '0; seed3 = '0;
    range_val = '0;
    rd_lat = 1; wr_lat = 1; rand_lat = 0; stray_en = 0;

    vecs[0] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 64'hFF, 64'h1234, 1, 1,
                64'h34, 64'h1235};
    vecs[1] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 64'hFF, 64'h1234, 2, 5,
                64'h34, 64'h1235};
    vecs[2] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 3, 2, 64'hDEF0_9ABC_5678_1234, 64'h0};
    vecs[3] = '{16'hBEEF, 16'h0001, 16'h8000, 16'h7777, 64'h0, 64'h7, 2, 3,
                64'h0, 64'h8};
    vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0, 1, 2, 64'hACE1_ACE1_ACE1_ACE1, 64'h1};

    for (int k = 0; k < 5; k++) apply_stimulus(vecs[k], k);

    // Zero seeds must still give a moving address stream
    wait_writes(6, 200, "zero_seed_run");
    check_output("addr_not_stuck", {63'b0, rd_changes >= 5}, 64'd1);

    // Repeated same address (range 0): scoreboard tracks each increment
    @(negedge clk);
    rst = 1'b1;
    seed0 = 16'h1111; seed1 = 16'h2222; seed2 = 16'h3333; seed3 = 16'h4444;
    range_val = 64'h0;
    mem[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    rd_lat = 2; wr_lat = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_writes(3, 100, "range0_run");
    check_output("range0_final", mem[0], 64'h1);

    // Reset in the middle of a write must drop req at once and restart the sequence
    @(negedge clk);
    rst = 1'b1;
    seed0 = 16'h1234; seed1 = 16'h5678; seed2 = 16'h9ABC; seed3 = 16'hDEF0;
    range_val = 64'hFF;
    rd_lat = 2; wr_lat = 5;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_writes(3, 200, "pre_reset_run");
    polls = 0;
    while (!(req && wr) && polls < 50) begin
      @(negedge clk);
      polls++;
    end
    check_output("reached_wr", {63'b0, req && wr}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check_output("async_req_drop", {63'b0, req}, 64'd0);
    check_output("async_wr_drop", {63'b0, wr}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_writes(1, 100, "post_reset_first");
    check_output("restart_addr", last_wr_addr, 64'h34);
    wait_writes(4, 200, "post_reset_run");

    // Long random run with random latencies and stray rdy pulses outside transactions
    @(negedge clk);
    rst = 1'b1;
    seed0 = 16'($urandom); seed1 = 16'($urandom);
    seed2 = 16'($urandom); seed3 = 16'($urandom);
    range_val = 64'hFF;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    rand_lat = 1; stray_en = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_writes(1500, 30000, "long_run");
    stray_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
